// File: rtl/mult_share_pkg.sv
// Shared widths and the operand bundle that sits in front of the shared multiplier.
package mult_share_pkg;
  localparam int OPW   = 16;
  localparam int PRODW = 32;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic           sgn;
  } mul_op_t;
endpackage

// File: rtl/mult_share_arb_rr_arbiter.sv
// Combinational round-robin pick: search starts one past ptr and wraps; the pointer lives in the parent.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  logic          found;
  logic [IW-1:0] sel;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sel     = '0;
    for (int i = 1; i <= N; i++) begin
      sel = IW'((int'(ptr) + i) % N);
      if (en && !found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end
endmodule

// File: rtl/mult_share_arb.sv
// Two-stage sequencer sharing one combinational multiplier: S1 holds the granted operands,
// S2 captures the product and presents it on the tagged response channel.
module mult_share_arb
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*OPW-1:0] req_a,
  input  logic [NUM_REQ*OPW-1:0] req_b,
  input  logic [NUM_REQ-1:0]     req_signed,
  output logic [OPW-1:0]         mul_a,
  output logic [OPW-1:0]         mul_b,
  output logic                   mul_signed,
  input  logic [PRODW-1:0]       mul_prod,
  input  logic                   mul_neg,
  input  logic                   mul_zero,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [PRODW-1:0]       rsp_prod,
  output logic                   rsp_neg,
  output logic                   rsp_zero,
  output logic [CNT_W-1:0]       op_count
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // Requesters hold valid and operands until accepted and never wait on ready to raise valid;
  // req_ready is combinational from req_valid. rsp_* are held stable while rsp_valid && !rsp_ready.
  logic               s1_valid;
  logic [ID_W-1:0]    s1_id;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  mul_op_t            s1_op;
  mul_op_t            sel_op;
  logic               s2_load;
  logic               s1_free;
  logic               accept;

  assign s2_load = s1_valid && (!rsp_valid || rsp_ready);
  assign s1_free = !s1_valid || s2_load;

  // rst_n gates the grant so req_ready reads 0 while reset is held.
  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .en      (s1_free && rst_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;

  always_comb begin
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_op.a   = req_a[i*OPW +: OPW];
        sel_op.b   = req_b[i*OPW +: OPW];
        sel_op.sgn = req_signed[i];
      end
    end
  end

  // Operands hold their last value when S1 empties so the multiplier inputs do not toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_op    <= '0;
      rr_ptr   <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_id    <= gnt_idx;
      s1_op    <= sel_op;
      rr_ptr   <= gnt_idx;
    end else if (s1_free) begin
      s1_valid <= 1'b0;
    end
  end

  assign mul_a      = s1_op.a;
  assign mul_b      = s1_op.b;
  assign mul_signed = s1_op.sgn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_prod  <= '0;
      rsp_neg   <= 1'b0;
      rsp_zero  <= 1'b0;
    end else if (s2_load) begin
      rsp_valid <= 1'b1;
      rsp_id    <= s1_id;
      rsp_prod  <= mul_prod;
      rsp_neg   <= mul_neg;
      rsp_zero  <= mul_zero;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (rsp_valid && rsp_ready) begin
      op_count <= op_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb with a behavioural multiplier and an in-order response model.
module tb_mult_share_arb;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int EW = IW + 2 + 32;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*16-1:0] req_a;
  logic [N*16-1:0] req_b;
  logic [N-1:0]  req_signed;
  logic [15:0]   mul_a;
  logic [15:0]   mul_b;
  logic          mul_signed;
  logic [31:0]   mul_prod;
  logic          mul_neg;
  logic          mul_zero;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [IW-1:0] rsp_id;
  logic [31:0]   rsp_prod;
  logic          rsp_neg;
  logic          rsp_zero;
  logic [15:0]   op_count;

  logic [15:0] op_a [N];
  logic [15:0] op_b [N];
  logic        op_s [N];

  logic [EW-1:0] exp_q[$];
  int            last_id;
  bit            s1_occ;
  bit            s2_occ;
  int            exp_count;
  int            n_checks;
  int            n_pass;

  logic [EW-1:0] rsp_pack;
  assign rsp_pack = {rsp_id, rsp_neg, rsp_zero, rsp_prod};

  mult_share_arb #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_signed (req_signed),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_signed (mul_signed),
    .mul_prod   (mul_prod),
    .mul_neg    (mul_neg),
    .mul_zero   (mul_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_prod   (rsp_prod),
    .rsp_neg    (rsp_neg),
    .rsp_zero   (rsp_zero),
    .op_count   (op_count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {neg, zero, prod}: low 32 bits of the (sign- or zero-extended) product.
  function automatic logic [33:0] mref(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [31:0] p;
    if (s) p = {{16{a[15]}}, a} * {{16{b[15]}}, b};
    else   p = {16'b0, a} * {16'b0, b};
    return {s & p[31], p == 32'd0, p};
  endfunction

  always_comb {mul_neg, mul_zero, mul_prod} = mref(mul_a, mul_b, mul_signed);

  always_comb begin
    req_a      = '0;
    req_b      = '0;
    req_signed = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*16 +: 16] = op_a[i];
      req_b[i*16 +: 16] = op_b[i];
      req_signed[i]     = op_s[i];
    end
  end

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    bit           found;
    int           idx;
    r     = '0;
    found = 1'b0;
    if (!rst_n || (s1_occ && s2_occ && !rsp_ready)) return r;
    for (int i = 1; i <= N; i++) begin
      idx = (last_id + i) % N;
      if (!found && req_valid[idx]) begin
        r[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    last_id   = N - 1;
    s1_occ    = 1'b0;
    s2_occ    = 1'b0;
    exp_count = 0;
  endtask

  task automatic rand_op(input int i);
    op_a[i] = 16'($urandom);
    op_b[i] = 16'($urandom);
    op_s[i] = 1'($urandom);
  endtask

  // Driver: record this cycle's handshakes in the model, then advance one clock.
  task automatic tick();
    logic [N-1:0] acc;
    bit move;
    bit resp;
    acc  = req_valid & req_ready;
    resp = s2_occ && rsp_ready;
    move = s1_occ && (!s2_occ || rsp_ready);
    if (resp) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      exp_count++;
    end
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        exp_q.push_back({IW'(i), mref(op_a[i], op_b[i], op_s[i])});
        last_id = i;
      end
    end
    s2_occ = move || (s2_occ && !rsp_ready);
    s1_occ = (acc != '0) || (s1_occ && !move);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
      op_s[i] = 1'b0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = '0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_pack !== '0) $display("FAIL reset_rsp got %h exp 0", rsp_pack); else n_pass++;
    n_checks++; if ({mul_a, mul_b, mul_signed} !== 33'd0) $display("FAIL reset_mul got %h exp 0", {mul_a, mul_b, mul_signed}); else n_pass++;
    n_checks++; if (op_count !== 16'd0) $display("FAIL reset_op_count got %0d exp 0", op_count); else n_pass++;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got %b exp 0000", req_ready); else n_pass++;
    req_valid = 4'b1111;
    #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL reset_first_grant got %b exp 0001", req_ready); else n_pass++;
    req_valid = '0;
  endtask

  int unsigned  t_id [5] = '{0, 2, 2, 1, 3};
  logic [15:0]  t_a  [5] = '{16'd5, 16'hFFF4, 16'hFFF4, 16'h0000, 16'h8000};
  logic [15:0]  t_b  [5] = '{16'd7, 16'h0003, 16'h0003, 16'hFFFF, 16'h0001};
  logic         t_s  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [31:0]  t_p  [5] = '{32'h00000023, 32'hFFFFFFDC, 32'h0002FFDC, 32'h00000000, 32'hFFFF8000};
  logic         t_n  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic         t_z  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic test_directed();
    logic [N-1:0] oh;
    for (int k = 0; k < 5; k++) begin
      oh = '0;
      oh[t_id[k]] = 1'b1;
      rsp_ready = 1'b1;
      op_a[t_id[k]] = t_a[k];
      op_b[t_id[k]] = t_b[k];
      op_s[t_id[k]] = t_s[k];
      req_valid = oh;
      #1;
      n_checks++; if (req_ready !== oh) $display("FAIL dir_ready[%0d] got %b exp %b", k, req_ready, oh); else n_pass++;
      tick();
      req_valid = '0;
      #1;
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL dir_latency[%0d] got %b exp 0", k, rsp_valid); else n_pass++;
      tick();
      #1;
      n_checks++; if (rsp_valid !== 1'b1) $display("FAIL dir_rsp_valid[%0d] got %b exp 1", k, rsp_valid); else n_pass++;
      n_checks++;
      if (rsp_pack !== {IW'(t_id[k]), t_n[k], t_z[k], t_p[k]})
        $display("FAIL dir_rsp[%0d] got %h exp %h", k, rsp_pack, {IW'(t_id[k]), t_n[k], t_z[k], t_p[k]});
      else n_pass++;
      tick();
      #1;
      n_checks++; if (op_count !== 16'(k + 1)) $display("FAIL dir_op_count[%0d] got %0d exp %0d", k, op_count, k + 1); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) rand_op(i);
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      a = req_ready;
      n_checks++; if (req_ready !== 4'(1 << (c % 4))) $display("FAIL b2b_grant[%0d] got %b exp %b", c, req_ready, 4'(1 << (c % 4))); else n_pass++;
      if (c >= 2) begin
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL b2b_rsp_valid[%0d] got %b exp 1", c, rsp_valid); else n_pass++;
        n_checks++; if (rsp_id !== IW'((c - 2) % 4)) $display("FAIL b2b_rsp_id[%0d] got %0d exp %0d", c, rsp_id, (c - 2) % 4); else n_pass++;
        n_checks++; if (rsp_pack !== exp_q[0]) $display("FAIL b2b_rsp[%0d] got %h exp %h", c, rsp_pack, exp_q[0]); else n_pass++;
      end
      tick();
      for (int i = 0; i < N; i++) if (a[i]) rand_op(i);
    end
    req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (s2_occ) begin
        n_checks++; if ({rsp_valid, rsp_pack} !== {1'b1, exp_q[0]}) $display("FAIL b2b_drain_rsp got %h exp %h", {rsp_valid, rsp_pack}, {1'b1, exp_q[0]}); else n_pass++;
      end
      tick();
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_lost got %0d pending exp 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] a;
    logic [N-1:0] exp_r [5] = '{4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    rsp_ready = 1'b0;
    rand_op(1);
    rand_op(3);
    req_valid = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      #1;
      a = req_valid & req_ready;
      n_checks++; if (req_ready !== exp_r[c]) $display("FAIL bp_ready[%0d] got %b exp %b", c, req_ready, exp_r[c]); else n_pass++;
      if (c >= 2) begin
        n_checks++; if ({rsp_valid, rsp_id} !== {1'b1, 2'd1}) $display("FAIL bp_hold_id[%0d] got %b/%0d exp 1/1", c, rsp_valid, rsp_id); else n_pass++;
        n_checks++; if (rsp_pack !== exp_q[0]) $display("FAIL bp_stable[%0d] got %h exp %h", c, rsp_pack, exp_q[0]); else n_pass++;
      end
      tick();
      req_valid = req_valid & ~a;
      for (int i = 0; i < N; i++) if (a[i]) rand_op(i);
      if (c == 1) req_valid = 4'b1010;
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      a = req_valid & req_ready;
      n_checks++; if (req_ready !== exp_ready()) $display("FAIL bp_rel_ready[%0d] got %b exp %b", c, req_ready, exp_ready()); else n_pass++;
      if (c < 2) begin
        n_checks++; if (rsp_id !== IW'(c * 2 + 1)) $display("FAIL bp_order[%0d] got %0d exp %0d", c, rsp_id, c * 2 + 1); else n_pass++;
      end
      if (s2_occ) begin
        n_checks++; if ({rsp_valid, rsp_pack} !== {1'b1, exp_q[0]}) $display("FAIL bp_rsp[%0d] got %h exp %h", c, {rsp_valid, rsp_pack}, {1'b1, exp_q[0]}); else n_pass++;
      end
      tick();
      req_valid = req_valid & ~a;
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL bp_lost got %0d pending exp 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_random();
    logic [N-1:0] a;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          rand_op(i);
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      a = req_valid & req_ready;
      n_checks++; if (req_ready !== exp_ready()) $display("FAIL rnd_ready[%0d] got %b exp %b", c, req_ready, exp_ready()); else n_pass++;
      n_checks++; if (rsp_valid !== s2_occ) $display("FAIL rnd_rsp_valid[%0d] got %b exp %b", c, rsp_valid, s2_occ); else n_pass++;
      if (s2_occ) begin
        n_checks++; if (rsp_pack !== exp_q[0]) $display("FAIL rnd_rsp[%0d] got %h exp %h", c, rsp_pack, exp_q[0]); else n_pass++;
      end
      tick();
      req_valid = req_valid & ~a;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (s2_occ) begin
        n_checks++; if ({rsp_valid, rsp_pack} !== {1'b1, exp_q[0]}) $display("FAIL rnd_drain got %h exp %h", {rsp_valid, rsp_pack}, {1'b1, exp_q[0]}); else n_pass++;
      end
      tick();
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL rnd_lost got %0d pending exp 0", exp_q.size()); else n_pass++;
    n_checks++; if (op_count !== 16'(exp_count)) $display("FAIL rnd_op_count got %0d exp %0d", op_count, 16'(exp_count)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    rand_op(3);
    rand_op(0);
    req_valid = 4'b1000;
    #1;
    n_checks++; if (req_ready !== exp_ready()) $display("FAIL rmid_fill3 got %b exp %b", req_ready, exp_ready()); else n_pass++;
    tick();
    req_valid = 4'b0001;
    #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL rmid_fill0 got %b exp 0001", req_ready); else n_pass++;
    tick();
    req_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL rmid_req_ready got %b exp 0000", req_ready); else n_pass++;
    n_checks++; if ({rsp_valid, rsp_pack} !== '0) $display("FAIL rmid_rsp got %h exp 0", {rsp_valid, rsp_pack}); else n_pass++;
    n_checks++; if ({mul_a, mul_b, mul_signed} !== 33'd0) $display("FAIL rmid_mul got %h exp 0", {mul_a, mul_b, mul_signed}); else n_pass++;
    n_checks++; if (op_count !== 16'd0) $display("FAIL rmid_op_count got %0d exp 0", op_count); else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b0011;
    #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL rmid_priority got %b exp 0001", req_ready); else n_pass++;
    tick();
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (s2_occ) begin
        n_checks++; if ({rsp_valid, rsp_pack} !== {1'b1, exp_q[0]}) $display("FAIL rmid_rsp_after got %h exp %h", {rsp_valid, rsp_pack}, {1'b1, exp_q[0]}); else n_pass++;
      end
      tick();
    end
    n_checks++; if (op_count !== 16'd1) $display("FAIL rmid_count_after got %0d exp 1", op_count); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    apply_reset();
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Sequencer and round-robin arbiter that shares one combinational booth16x16_top multiplier among NUM_REQ requesters. It accepts operand requests over per-requester valid/ready handshakes and registers the winning operands in front of the multiplier. It captures the product and flags in a result register and returns them, tagged with the requester ID, over a single valid/ready response channel. It sits between the ALU issue logic and the shared multiplier instance.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(NUM_REQ), width of requester ID

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- req_a  in  NUM_REQ*16  operand A, requester i at [16i+15:16i]
- req_b  in  NUM_REQ*16  operand B, same packing
- req_signed  in  NUM_REQ  1 = signed multiply
- mul_a, mul_b  out  16  operands to multiplier A/B
- mul_signed  out  1  to multiplier alu_signed
- mul_prod  in  32  multiplier PROD_RESULT
- mul_neg, mul_zero  in  1  multiplier neg_flag / zero_flag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  requester index of response
- rsp_prod  out  32  product
- rsp_neg, rsp_zero  out  1  captured flags
- op_count  out  16  completed responses, wraps 0xFFFF->0

## Operation
- Stage S1 (operand reg): s1_valid, s1_id, mul_a, mul_b, mul_signed. Stage S2 (result reg): rsp_valid, rsp_id, rsp_prod, rsp_neg, rsp_zero.
- s2_load = s1_valid && (!rsp_valid || rsp_ready); s1_free = !s1_valid || s2_load.
- Grant: round-robin over req_valid starting at rr_ptr+1 mod NUM_REQ. req_ready[g] = s1_free && req_valid[g]; other bits 0. req_ready depends combinationally on req_valid; requesters must not make valid depend on ready.
- On accept (req_valid[g] && req_ready[g]): load S1 with requester g's operands, s1_id=g, rr_ptr=g. rr_ptr is unchanged on cycles with no accept.
- If s1_free and no accept: s1_valid clears; mul_a/mul_b/mul_signed hold last value (no toggling).
- On s2_load: capture mul_prod/mul_neg/mul_zero, rsp_id=s1_id, rsp_valid=1. If rsp_valid && rsp_ready && !s2_load: rsp_valid clears.
- op_count increments on every rsp_valid && rsp_ready.
- Responses return in acceptance order. Nothing is dropped or duplicated.
- Arithmetic is done entirely by the multiplier. The block only forwards bits, with no width change: 16-bit operands, 32-bit product.

## Timing
- Reset values: req_ready 0, mul_a 0, mul_b 0, mul_signed 0, rsp_valid 0, rsp_id 0, rsp_prod 0, rsp_neg 0, rsp_zero 0, op_count 0, s1_valid 0, rr_ptr NUM_REQ-1 (requester 0 wins first).
- Latency: accept at edge N -> S1 valid after N -> rsp_valid high after edge N+1.
- Throughput: one result per cycle while rsp_ready=1.
- Backpressure: with rsp_ready=0, S2 holds stable and S1 holds one more op, after which all req_ready=0. When rsp_ready rises, S2 drains and S1 advances in the same cycle.
- Simultaneous S2 drain and S1 load, and S1 drain and new accept, both occur in one cycle with no bubble.
- rsp_* outputs stay stable while rsp_valid && !rsp_ready.
- Reset mid-operation: in-flight S1/S2 contents are discarded and all outputs return to reset values immediately (async).

## Structure
- Package mult_share_pkg: OPW=16, PRODW=32, CNT_W=16, and a typedef mul_op_t {logic [OPW-1:0] a, b; logic sgn;}.
- Sub-module rr_arbiter (parameter N): inputs req, ptr, en; outputs a one-hot grant and a grant index. It is combinational, and the pointer register lives in the parent.
- The multiplier is not instantiated inside. The top level connects mul_* to booth16x16_top.

## Test plan
- Reset, then req_valid[0] with A=5, B=7, unsigned -> rsp_valid two edges after accept, rsp_prod=0x00000023, rsp_id=0, neg=0, zero=0, op_count=1.
- Requester 2, signed, A=0xFFF4 (-12), B=0x0003 -> rsp_prod=0xFFFFFFDC, rsp_neg=1, rsp_id=2. Same operands unsigned -> 0x0002FFDC.
- All four requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles and responses in that rsp_id order, one per cycle.
- rsp_ready=0 for 4 cycles with requesters 1 and 3 valid -> two accepts, then req_ready=0. rsp_* stay stable. Release gives responses in order 1 then 3 with no loss.
- A=0x0000, B=0xFFFF, signed -> rsp_prod=0, rsp_zero=1. A=0x8000, B=0x0001, signed -> 0xFFFF8000, neg=1.
- Assert rst_n low with S1 and S2 full -> all outputs at reset values at once. After release, requester 0 has priority even if rr_ptr was 0 before reset.
